// File: rtl/id_stage_p.sv
// Instruction-decode stage: decode, register file with write-through, RAW hazard
// detection and the ID/EX register. Optional operand forwarding under ID_FWD_EN.
module id_stage_p #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr,
    input  logic [PC_W-1:0]  pc_in,
    input  logic             wb_en,
    input  logic [4:0]       wb_dest,
    input  logic [XLEN-1:0]  wb_data,
    input  logic             exe_wb_en,
    input  logic [4:0]       exe_dest,
    input  logic             exe_mem_read,
    input  logic [XLEN-1:0]  exe_fwd_data,
    input  logic             mem_wb_en,
    input  logic [4:0]       mem_dest,
    input  logic [XLEN-1:0]  mem_fwd_data,
    input  logic             flush_in,
    output logic             stall_out,
    output logic             ex_valid,
    output logic             ex_wb_en,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic [1:0]       ex_branch,
    output logic [3:0]       ex_cmd,
    output logic [4:0]       ex_dest,
    output logic [XLEN-1:0]  ex_val1,
    output logic [XLEN-1:0]  ex_val2,
    output logic [XLEN-1:0]  ex_reg2,
    output logic [PC_W-1:0]  ex_pc,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam int IDX_W = $clog2(NREGS);

    typedef struct packed {
        logic            valid;
        logic            wb_en;
        logic            mem_read;
        logic            mem_write;
        logic [1:0]      branch;
        logic [3:0]      cmd;
        logic [4:0]      dest;
        logic [XLEN-1:0] val1;
        logic [XLEN-1:0] val2;
        logic [XLEN-1:0] reg2;
        logic [PC_W-1:0] pc;
    } idex_t;

    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm16;

    assign op    = instr[31:26];
    assign rs    = instr[25:21];
    assign rt    = instr[20:16];
    assign rd    = instr[15:11];
    assign imm16 = instr[15:0];

    logic       dec_wb;
    logic       dec_mr;
    logic       dec_mw;
    logic [1:0] dec_br;
    logic [3:0] dec_cmd;
    logic       dec_imm;
    logic       is_r;
    logic       use_rs;
    logic       use_rt;

    always_comb begin
        dec_wb  = 1'b0;
        dec_mr  = 1'b0;
        dec_mw  = 1'b0;
        dec_br  = 2'b00;
        dec_cmd = 4'b0000;
        dec_imm = 1'b0;
        is_r    = 1'b0;
        use_rs  = 1'b0;
        case (op)
            6'h01: begin is_r = 1'b1; dec_cmd = 4'b0000; end
            6'h03: begin is_r = 1'b1; dec_cmd = 4'b0010; end
            6'h05: begin is_r = 1'b1; dec_cmd = 4'b0100; end
            6'h06: begin is_r = 1'b1; dec_cmd = 4'b0101; end
            6'h07: begin is_r = 1'b1; dec_cmd = 4'b0110; end
            6'h08: begin is_r = 1'b1; dec_cmd = 4'b0111; end
            6'h09: begin is_r = 1'b1; dec_cmd = 4'b1000; end
            6'h0A: begin is_r = 1'b1; dec_cmd = 4'b1000; end
            6'h0B: begin is_r = 1'b1; dec_cmd = 4'b1001; end
            6'h0C: begin is_r = 1'b1; dec_cmd = 4'b1010; end
            6'h20: begin dec_wb = 1'b1; dec_imm = 1'b1; use_rs = 1'b1; dec_cmd = 4'b0000; end
            6'h21: begin dec_wb = 1'b1; dec_imm = 1'b1; use_rs = 1'b1; dec_cmd = 4'b0010; end
            6'h24: begin dec_wb = 1'b1; dec_mr = 1'b1; use_rs = 1'b1; end
            6'h25: begin dec_mw = 1'b1; use_rs = 1'b1; end
            6'h28: begin dec_br = 2'b01; use_rs = 1'b1; end
            6'h29: begin dec_br = 2'b10; use_rs = 1'b1; end
            6'h2A: begin dec_br = 2'b11; end
            default: ;
        endcase
        if (is_r) begin
            dec_wb = 1'b1;
            use_rs = 1'b1;
        end
        use_rt = is_r | dec_mw | (dec_br == 2'b10);
    end

    // Register file: flop array so reset can clear every entry in one cycle.
    logic [XLEN-1:0]  regs_reg [NREGS];
    logic [IDX_W-1:0] wb_idx;

    assign wb_idx = wb_dest[IDX_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (wb_en && wb_idx != '0) begin
            regs_reg[wb_idx] <= wb_data;
        end
    end

    // Index 0 = rs port, index 1 = rt port.
    logic [1:0][4:0]      src_field;
    logic [1:0][XLEN-1:0] src_val;
    logic [1:0][XLEN-1:0] opnd;
    logic [1:0]           exe_hit;
    logic [1:0]           mem_hit;
    logic [1:0]           src_used;
    logic                 hazard;

    assign src_field = {rt, rs};
    assign src_used  = {use_rt, use_rs};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            logic [IDX_W-1:0] idx;
            assign idx = src_field[gi][IDX_W-1:0];
            assign src_val[gi] = (idx == '0) ? '0 :
                                 (wb_en && wb_idx == idx) ? wb_data : regs_reg[idx];
            assign exe_hit[gi] = (src_field[gi] != 5'd0) && exe_wb_en && (exe_dest == src_field[gi]);
            assign mem_hit[gi] = (src_field[gi] != 5'd0) && mem_wb_en && (mem_dest == src_field[gi]);
`ifdef ID_FWD_EN
            assign opnd[gi] = exe_hit[gi] ? exe_fwd_data :
                              mem_hit[gi] ? mem_fwd_data : src_val[gi];
`else
            assign opnd[gi] = src_val[gi];
`endif
        end
    endgenerate

`ifdef ID_FWD_EN
    // Only a load sitting in EXE cannot be forwarded yet.
    assign hazard = (|(exe_hit & src_used)) && exe_mem_read;
`else
    logic unused_fwd;
    assign unused_fwd = ^{exe_fwd_data, mem_fwd_data, exe_mem_read};
    assign hazard = |((exe_hit | mem_hit) & src_used);
`endif

    assign stall_out = hazard && !flush_in && !rst;

    idex_t idex_reg;
    idex_t idex_next;

    always_comb begin
        idex_next = '0;
        if (!flush_in && !stall_out) begin
            idex_next.valid     = 1'b1;
            idex_next.wb_en     = dec_wb;
            idex_next.mem_read  = dec_mr;
            idex_next.mem_write = dec_mw;
            idex_next.branch    = dec_br;
            idex_next.cmd       = dec_cmd;
            idex_next.dest      = dec_imm ? rt : rd;
            idex_next.val1      = opnd[0];
            idex_next.val2      = dec_imm ? {{(XLEN-16){imm16[15]}}, imm16} : opnd[1];
            idex_next.reg2      = opnd[1];
            idex_next.pc        = pc_in;
        end
    end

    logic [CNT_W-1:0] stall_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            idex_reg      <= '0;
            stall_cnt_reg <= '0;
        end else begin
            idex_reg <= idex_next;
            if (stall_out && stall_cnt_reg != '1) begin
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            end
        end
    end

    assign ex_valid     = idex_reg.valid;
    assign ex_wb_en     = idex_reg.wb_en;
    assign ex_mem_read  = idex_reg.mem_read;
    assign ex_mem_write = idex_reg.mem_write;
    assign ex_branch    = idex_reg.branch;
    assign ex_cmd       = idex_reg.cmd;
    assign ex_dest      = idex_reg.dest;
    assign ex_val1      = idex_reg.val1;
    assign ex_val2      = idex_reg.val2;
    assign ex_reg2      = idex_reg.reg2;
    assign ex_pc        = idex_reg.pc;
    assign stall_cnt    = stall_cnt_reg;
endmodule

// File: tb/tb_id_stage_p.sv
// Self-checking bench for id_stage_p: vector table plus hand-written hazard,
// saturation and reset sequences; expected ID/EX contents go through a queue.
module tb_id_stage_p;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int PC_W  = 32;
    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [31:0]      instr = '0;
    logic [PC_W-1:0]  pc_in = '0;
    logic             wb_en = 1'b0;
    logic [4:0]       wb_dest = '0;
    logic [XLEN-1:0]  wb_data = '0;
    logic             exe_wb_en = 1'b0;
    logic [4:0]       exe_dest = '0;
    logic             exe_mem_read = 1'b0;
    logic [XLEN-1:0]  exe_fwd_data = '0;
    logic             mem_wb_en = 1'b0;
    logic [4:0]       mem_dest = '0;
    logic [XLEN-1:0]  mem_fwd_data = '0;
    logic             flush_in = 1'b0;
    logic             stall_out;
    logic             ex_valid, ex_wb_en, ex_mem_read, ex_mem_write;
    logic [1:0]       ex_branch;
    logic [3:0]       ex_cmd;
    logic [4:0]       ex_dest;
    logic [XLEN-1:0]  ex_val1, ex_val2, ex_reg2;
    logic [PC_W-1:0]  ex_pc;
    logic [CNT_W-1:0] stall_cnt;

    always #5 clk = ~clk;

    id_stage_p #(.XLEN(XLEN), .NREGS(NREGS), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .instr(instr), .pc_in(pc_in),
        .wb_en(wb_en), .wb_dest(wb_dest), .wb_data(wb_data),
        .exe_wb_en(exe_wb_en), .exe_dest(exe_dest), .exe_mem_read(exe_mem_read),
        .exe_fwd_data(exe_fwd_data), .mem_wb_en(mem_wb_en), .mem_dest(mem_dest),
        .mem_fwd_data(mem_fwd_data), .flush_in(flush_in), .stall_out(stall_out),
        .ex_valid(ex_valid), .ex_wb_en(ex_wb_en), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_branch(ex_branch), .ex_cmd(ex_cmd),
        .ex_dest(ex_dest), .ex_val1(ex_val1), .ex_val2(ex_val2), .ex_reg2(ex_reg2),
        .ex_pc(ex_pc), .stall_cnt(stall_cnt)
    );

    typedef struct packed {
        logic        valid;
        logic        wb;
        logic        mr;
        logic        mw;
        logic [1:0]  br;
        logic [3:0]  cmd;
        logic [4:0]  dest;
        logic [31:0] val1;
        logic [31:0] val2;
        logic [31:0] reg2;
        logic [31:0] pc;
    } out_t;

    typedef struct packed {
        logic        rst;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        wb_en;
        logic [4:0]  wb_dest;
        logic [31:0] wb_data;
        logic        exe_wb_en;
        logic [4:0]  exe_dest;
        logic        exe_mr;
        logic [31:0] exe_fwd;
        logic        mem_wb_en;
        logic [4:0]  mem_dest;
        logic [31:0] mem_fwd;
        logic        flush;
        logic        stall;
        out_t        exp;
    } vec_t;

    int   tests_run = 0;
    int   tests_failed = 0;
    int   model_cnt = 0;
    int   pc_ctr = 0;
    out_t exp_q[$];
    vec_t tbl[$];
    out_t BUB = '0;

    function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] rtype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd);
        return {op, rs, rt, rd, 11'b0};
    endfunction

    function automatic out_t o(input logic wb, input logic mr, input logic mw,
                               input logic [1:0] br, input logic [3:0] cmd, input logic [4:0] dest,
                               input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] r2);
        return {1'b1, wb, mr, mw, br, cmd, dest, v1, v2, r2, 32'h0};
    endfunction

    function automatic vec_t mk(input logic [31:0] ins, input out_t e, input logic st);
        vec_t v;
        v = '0;
        v.instr = ins;
        v.exp = e;
        v.stall = st;
        v.pc = 32'h1000 + 32'(pc_ctr * 4);
        pc_ctr++;
        return v;
    endfunction

    task automatic check(input string name, input logic [159:0] got, input logic [159:0] expv);
        tests_run++;
        if (got !== expv) begin
            tests_failed++;
            $display("FAIL %s actual=%h required=%h", name, got, expv);
        end
    endtask

    task automatic apply(input vec_t v, input string name);
        out_t e;
        out_t got;
        rst = v.rst; instr = v.instr; pc_in = v.pc;
        wb_en = v.wb_en; wb_dest = v.wb_dest; wb_data = v.wb_data;
        exe_wb_en = v.exe_wb_en; exe_dest = v.exe_dest; exe_mem_read = v.exe_mr;
        exe_fwd_data = v.exe_fwd; mem_wb_en = v.mem_wb_en; mem_dest = v.mem_dest;
        mem_fwd_data = v.mem_fwd; flush_in = v.flush;
        #1;
        check({name, "_stall"}, 160'(stall_out), 160'(v.stall));
        if (v.rst) model_cnt = 0;
        else if (v.stall && model_cnt != CNT_MAX) model_cnt++;
        e = v.exp;
        if (e.valid) e.pc = v.pc;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got = {ex_valid, ex_wb_en, ex_mem_read, ex_mem_write, ex_branch, ex_cmd, ex_dest,
               ex_val1, ex_val2, ex_reg2, ex_pc};
        e = exp_q.pop_front();
        check({name, "_idex"}, 160'(got), 160'(e));
        check({name, "_cnt"}, 160'(stall_cnt), 160'(model_cnt));
        $display("[TB] %-10s instr=%h stall=%b valid=%b val1=%h val2=%h cnt=%0d",
                 name, v.instr, stall_out, ex_valid, ex_val1, ex_val2, stall_cnt);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;

        // ---- vector table ----
        v = mk(32'h80010005, o(1,0,0,2'd0,4'h0,5'd1,32'd0,32'd5,32'd0), 0); tbl.push_back(v);
        v = mk(rtype(6'h01,3,0,4), o(1,0,0,2'd0,4'h0,5'd4,32'h1234,32'd0,32'd0), 0);
        v.wb_en = 1; v.wb_dest = 3; v.wb_data = 32'h1234; tbl.push_back(v);
        v = mk(enc(6'h21,3,5,16'hFFFF), o(1,0,0,2'd0,4'h2,5'd5,32'h1234,32'hFFFFFFFF,32'd0), 0); tbl.push_back(v);
        v = mk(32'h0, o(0,0,0,2'd0,4'h0,5'd0,32'd0,32'd0,32'd0), 0);
        v.wb_en = 1; v.wb_dest = 7; v.wb_data = 32'hABCD; tbl.push_back(v);
        v = mk(enc(6'h25,3,7,16'h0010), o(0,0,1,2'd0,4'h0,5'd0,32'h1234,32'hABCD,32'hABCD), 0); tbl.push_back(v);
        v = mk(enc(6'h24,3,0,16'h3000), o(1,1,0,2'd0,4'h0,5'd6,32'h1234,32'd0,32'd0), 0); tbl.push_back(v);
        v = mk(enc(6'h29,7,3,16'h0000), o(0,0,0,2'd2,4'h0,5'd0,32'hABCD,32'h1234,32'h1234), 0); tbl.push_back(v);
        v = mk(enc(6'h2A,0,0,16'h8000), o(0,0,0,2'd3,4'h0,5'd16,32'd0,32'd0,32'd0), 0); tbl.push_back(v);
        v = mk(rtype(6'h08,7,3,8), o(1,0,0,2'd0,4'h7,5'd8,32'hABCD,32'h1234,32'h1234), 0); tbl.push_back(v);
        v = mk(enc(6'h3F,0,0,16'h0007), o(0,0,0,2'd0,4'h0,5'd0,32'd0,32'd0,32'd0), 0); tbl.push_back(v);
        v = mk(rtype(6'h0B,7,0,9), o(1,0,0,2'd0,4'h9,5'd9,32'hABCD,32'd0,32'd0), 0); tbl.push_back(v);
        v = mk(rtype(6'h01,0,0,10), o(1,0,0,2'd0,4'h0,5'd10,32'd0,32'd0,32'd0), 0);
        v.wb_en = 1; v.wb_dest = 0; v.wb_data = 32'hFF; tbl.push_back(v);
        v = mk(rtype(6'h01,0,0,10), o(1,0,0,2'd0,4'h0,5'd10,32'd0,32'd0,32'd0), 0); tbl.push_back(v);
`ifdef ID_FWD_EN
        v = mk(rtype(6'h03,2,3,11), o(1,0,0,2'd0,4'h2,5'd11,32'h55,32'h1234,32'h1234), 0);
`else
        v = mk(rtype(6'h03,2,3,11), BUB, 1);
`endif
        v.exe_wb_en = 1; v.exe_dest = 2; v.exe_fwd = 32'h55; tbl.push_back(v);
        v.pc = v.pc + 32'h100; v.flush = 1; v.stall = 0; v.exp = BUB; tbl.push_back(v);
`ifdef ID_FWD_EN
        v = mk(rtype(6'h01,7,3,12), o(1,0,0,2'd0,4'h0,5'd12,32'hABCD,32'h77,32'h77), 0);
`else
        v = mk(rtype(6'h01,7,3,12), BUB, 1);
`endif
        v.mem_wb_en = 1; v.mem_dest = 3; v.mem_fwd = 32'h77; tbl.push_back(v);
`ifdef ID_FWD_EN
        v = mk(enc(6'h20,7,13,16'd3), o(1,0,0,2'd0,4'h0,5'd13,32'h11,32'd3,32'd0), 0);
`else
        v = mk(enc(6'h20,7,13,16'd3), BUB, 1);
`endif
        v.exe_wb_en = 1; v.exe_dest = 7; v.exe_fwd = 32'h11;
        v.mem_wb_en = 1; v.mem_dest = 7; v.mem_fwd = 32'h22; tbl.push_back(v);
        v = mk(enc(6'h20,0,14,16'd9), o(1,0,0,2'd0,4'h0,5'd14,32'd0,32'd9,32'd0), 0);
        v.exe_wb_en = 1; v.exe_dest = 0; v.exe_fwd = 32'h33; tbl.push_back(v);
        v = mk(enc(6'h20,3,15,16'd1), o(1,0,0,2'd0,4'h0,5'd15,32'h1234,32'd1,32'd0), 0);
        v.exe_wb_en = 1; v.exe_dest = 15; tbl.push_back(v);
        v = mk(rtype(6'h01,2,0,12), BUB, 1);
        v.exe_wb_en = 1; v.exe_dest = 2; v.exe_mr = 1; v.exe_fwd = 32'h44; tbl.push_back(v);

        // ---- reset ----
        v = '0; v.rst = 1; v.exp = BUB;
        for (int i = 0; i < 3; i++) apply(v, $sformatf("reset%0d", i));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

        // ---- producer directly ahead: EXE, then MEM, then write-back ----
        v = mk(enc(6'h20,0,2,16'd7), o(1,0,0,2'd0,4'h0,5'd2,32'd0,32'd7,32'd0), 0);
        apply(v, "dep_prod");
        v = mk(rtype(6'h03,2,3,11), BUB, 1);
        v.exe_wb_en = 1; v.exe_dest = 2; v.exe_mr = 1;
        apply(v, "dep_exe");
`ifdef ID_FWD_EN
        v = mk(rtype(6'h03,2,3,11), o(1,0,0,2'd0,4'h2,5'd11,32'd7,32'h1234,32'h1234), 0);
`else
        v = mk(rtype(6'h03,2,3,11), BUB, 1);
`endif
        v.mem_wb_en = 1; v.mem_dest = 2; v.mem_fwd = 32'd7;
        apply(v, "dep_mem");
        v = mk(rtype(6'h03,2,3,11), o(1,0,0,2'd0,4'h2,5'd11,32'd7,32'h1234,32'h1234), 0);
        v.wb_en = 1; v.wb_dest = 2; v.wb_data = 32'd7;
        apply(v, "dep_wb");

        // ---- saturation of the stall counter ----
        v = mk(rtype(6'h03,2,3,11), BUB, 1);
        v.exe_wb_en = 1; v.exe_dest = 2; v.exe_mr = 1;
        for (int i = 0; i < (1 << CNT_W) + 3; i++) apply(v, $sformatf("sat%0d", i));

        // ---- reset in the middle of a stall ----
        v.rst = 1; v.stall = 0; v.exp = BUB;
        apply(v, "rst_stall");
        v = mk(rtype(6'h01,3,7,4), o(1,0,0,2'd0,4'h0,5'd4,32'd0,32'd0,32'd0), 0);
        apply(v, "rf_clear");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/id_stage_p.md
# id_stage_p

Parametrised instruction-decode stage with hazard control: decodes the 6-bit-opcode ISA, reads a parameterised register file, sign-extends immediates, detects read-after-write hazards against the EXE and MEM stages and inserts bubbles or forwards results. Sits between the IF/ID register and the EXE stage, and owns the ID/EX pipeline register. The IF stage uses its stall output to freeze, and EXE branch resolution drives its flush input.

## Interface
- XLEN, 32: datapath and register width (≥16).
- NREGS, 32: register count; power of 2, 2..32. Index = low log2(NREGS) bits of each 5-bit field.
- PC_W, 32: PC width.
- CNT_W, 16: stall-counter width.
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- instr  in  32  IF/ID instruction: [31:26] op, [25:21] rs, [20:16] rt, [15:11] rd, [15:0] imm.
- pc_in  in  PC_W  IF/ID PC.
- wb_en, wb_dest, wb_data  in  1/5/XLEN  write-back port.
- exe_wb_en, exe_dest, exe_mem_read, exe_fwd_data  in  1/5/1/XLEN  EXE-stage producer info.
- mem_wb_en, mem_dest, mem_fwd_data  in  1/5/XLEN  MEM-stage producer info.
- flush_in  in  1  squash the instruction currently in ID.
- stall_out  out  1  combinational; IF/ID and PC must hold.
- ex_valid, ex_wb_en, ex_mem_read, ex_mem_write  out  1 each  ID/EX control.
- ex_branch  out  2  00 none, 01 BEZ, 10 BNE, 11 JMP.
- ex_cmd  out  4  ALU command.
- ex_dest  out  5  destination register.
- ex_val1, ex_val2, ex_reg2  out  XLEN  operand A, operand B (reg or imm), store/compare data.
- ex_pc  out  PC_W  registered PC.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

## Operation
- Decode uses {wb, rd, wr, br, cmd, imm} per opcode. Unlisted opcodes decode as NOP.
  - 00 NOP: all zero.
  - R-type, wb=1, cmd: 01 ADD 0000, 03 SUB 0010, 05 AND 0100, 06 OR 0101, 07 NOR 0110, 08 XOR 0111, 09 SLA 1000, 0A SLL 1000, 0B SRA 1001, 0C SRL 1010.
  - Immediate, imm=1: 20 ADDI 0000, 21 SUBI 0010.
  - Memory: 24 LD wb, rd. 25 ST wr.
  - Branch: 28 BEZ br01, 29 BNE br10, 2A JMP br11.
- dest = imm ? rt : rd. val2 = imm ? sext(imm16 to XLEN) : R[rt].
- Register file:
  - Reset clears all entries.
  - R0 reads 0; writes to R0 are ignored.
  - Write on posedge when wb_en.
  - A same-cycle read of wb_dest returns wb_data (write-through).
- Source use:
  - use_rs for every non-NOP opcode except JMP.
  - use_rt for R-type, ST and BNE.
- Hazard on a source s, with s≠0 and use_s:
  - EXE match: exe_wb_en && exe_dest==s.
  - MEM match: mem_wb_en && mem_dest==s.
  - Write-back is covered by write-through and never stalls.
- stall_out = hazard && !flush_in && !rst.
- ID/EX update priority: rst, then flush_in (bubble), then stall (bubble), otherwise load the decoded instruction with ex_valid=1.
- A bubble sets every control bit to zero, ex_valid=0 and data to zero.
- stall_cnt increments each cycle stall_out=1 and saturates at all-ones.

## Timing
- Reset: all ex_* outputs are 0, stall_cnt is 0, stall_out is 0, and the register file is zeroed.
- Decode to ID/EX latency is 1 cycle.
- A stall lasts as long as the producer occupies EXE/MEM. Without forwarding, a dependent instruction directly behind its producer stalls 2 cycles, then issues with the write-through value.
- When flush and hazard occur together, flush wins: bubble, no stall.
- Reset mid-stall clears the ID/EX register and stall_cnt on the next edge.

## Configuration
- ID_FWD_EN defined:
  - Operands rs/rt take exe_fwd_data on an EXE match, else mem_fwd_data on a MEM match. EXE has priority.
  - Forwarding applies to val1, val2 (when imm=0) and reg2.
  - A stall is raised only on an EXE match with exe_mem_read=1 (load-use, 1 cycle).
- ID_FWD_EN undefined: stall rule as in Operation, no forwarding muxes.

## Test plan
- Reset, then ADDI R1,R0,5 (instr 0x80010005) → next cycle ex_cmd=0, ex_val1=0, ex_val2=5, ex_dest=1, ex_wb_en=1, ex_valid=1.
- Write-back wb_en=1, wb_dest=3, wb_data=0x1234 while decoding ADD R4,R3,R0 → ex_val1=0x1234 in the same-cycle decode.
- Without macro: exe_wb_en=1, exe_dest=2, decoding SUB using R2 → stall_out=1, ex_valid=0, stall_cnt=1. With macro and exe_mem_read=0 → no stall, ex_val1=exe_fwd_data.
- Macro on: exe_mem_read=1, exe_dest=2, dependent instruction → exactly 1 stall cycle, then issue with mem_fwd_data.
- flush_in=1 during a hazard → stall_out=0, ex_valid=0. Write to R0 of 0xFF, then read → 0.
- Hold a hazard for 2^CNT_W+3 cycles → stall_cnt saturates at all-ones. Assert rst → all outputs return to 0 next edge.
